// File: rtl/dmem_pkg.sv
// Shared types and helpers for the sized data memory: access-size codes,
// controller states and the byte count of an access.
package dmem_pkg;

  typedef logic [1:0] size_t;

  localparam size_t SZ_B = 2'b00;
  localparam size_t SZ_H = 2'b01;
  localparam size_t SZ_W = 2'b10;
  localparam size_t SZ_D = 2'b11;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  function automatic logic [3:0] size_bytes(input size_t size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/dmem_sized_if.sv
// Request/response bundle between the execute stage (master) and the data
// memory (slave), including the clear-sweep control pair.
interface dmem_sized_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  import dmem_pkg::*;

  logic                  clear_req;
  logic                  busy;
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  size_t                 req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_fault;

  modport master (
    output clear_req, req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  busy, req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  clear_req, req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output busy, req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

endinterface

// File: rtl/dmem_align.sv
// Byte-lane steering for the data memory: store byte enables and data shift,
// plus load right-justification with sign or zero extension.
module dmem_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  size_t                              i_st_size,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    i_st_lane,
  input  logic [DATA_WIDTH-1:0]              i_st_wdata,
  output logic [DATA_WIDTH/8-1:0]            o_st_be,
  output logic [DATA_WIDTH-1:0]              o_st_wdata,
  input  size_t                              i_ld_size,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]    i_ld_lane,
  input  logic                               i_ld_unsigned,
  input  logic [DATA_WIDTH-1:0]              i_ld_word,
  output logic [DATA_WIDTH-1:0]              o_ld_data
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic [7:0]            w_mask8;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [DATA_WIDTH-1:0] w_keep;
  logic                  w_sign;

  always_comb begin
    case (i_st_size)
      SZ_B:    w_mask8 = 8'h01;
      SZ_H:    w_mask8 = 8'h03;
      SZ_W:    w_mask8 = 8'h0F;
      default: w_mask8 = 8'hFF;
    endcase
    o_st_be    = w_mask8[BYTES-1:0] << i_st_lane;
    o_st_wdata = i_st_wdata << {i_st_lane, 3'b000};
  end

  // A full-width access keeps every bit, so its extension mask is empty.
  always_comb begin
    w_shift = i_ld_word >> {i_ld_lane, 3'b000};
    case (i_ld_size)
      SZ_B:    begin w_keep = DATA_WIDTH'(8'hFF);         w_sign = w_shift[7];  end
      SZ_H:    begin w_keep = DATA_WIDTH'(16'hFFFF);      w_sign = w_shift[15]; end
      SZ_W:    begin w_keep = DATA_WIDTH'(32'hFFFF_FFFF); w_sign = w_shift[31]; end
      default: begin w_keep = '1;                         w_sign = 1'b0;        end
    endcase
    o_ld_data = (w_shift & w_keep) | ((w_sign && !i_ld_unsigned) ? ~w_keep : '0);
  end

endmodule

// File: rtl/dmem_sized.sv
// Single-port sized data memory with fault checking, a one-cycle registered
// response and a post-reset sequential clear sweep.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int                    DEPTH      = 1024,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h0000_1000)
) (
  input logic         clk,
  input logic         reset,
  dmem_sized_if.slave bus
);
  localparam int                    BYTES     = DATA_WIDTH / 8;
  localparam int                    LW        = $clog2(BYTES);
  localparam int                    IW        = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] WIN_BYTES = ADDR_WIDTH'(DEPTH * BYTES);
  localparam logic [IW-1:0]         LAST_IDX  = IW'(DEPTH - 1);

  state_t                r_state;
  logic [IW-1:0]         r_clr_cnt;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_off;
  logic [IW-1:0]         w_idx;
  logic [LW-1:0]         w_lane;
  logic [3:0]            w_nbytes;
  logic                  w_fault;
  logic                  w_accept;
  logic                  w_store;
  logic [BYTES-1:0]      w_be;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [DATA_WIDTH-1:0] w_ld_data;

  logic                  r_vld_p1;
  logic                  r_fault_p1;
  logic                  r_load_p1;
  size_t                 r_size_p1;
  logic [LW-1:0]         r_lane_p1;
  logic                  r_uns_p1;
  logic [DATA_WIDTH-1:0] r_word_p1;

  assign w_off    = bus.req_addr - BASE_ADDR;
  assign w_idx    = w_off[LW +: IW];
  assign w_lane   = w_off[LW-1:0];
  assign w_nbytes = size_bytes(bus.req_size);
  assign w_fault  = (bus.req_addr < BASE_ADDR) || (w_off >= WIN_BYTES) ||
                    ((w_off[3:0] & (w_nbytes - 4'd1)) != 4'd0) ||
                    ((bus.req_size == SZ_D) && (DATA_WIDTH == 32));
  assign w_accept = bus.req_valid && (r_state == ST_READY);
  assign w_store  = w_accept && bus.req_we && !w_fault;

  dmem_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .i_st_size     (bus.req_size),
    .i_st_lane     (w_lane),
    .i_st_wdata    (bus.req_wdata),
    .o_st_be       (w_be),
    .o_st_wdata    (w_wdata),
    .i_ld_size     (r_size_p1),
    .i_ld_lane     (r_lane_p1),
    .i_ld_unsigned (r_uns_p1),
    .i_ld_word     (r_word_p1),
    .o_ld_data     (w_ld_data)
  );

  // An accepted request still completes when clear_req arrives alongside it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_CLEAR;
      r_clr_cnt  <= '0;
      r_vld_p1   <= 1'b0;
      r_fault_p1 <= 1'b0;
      r_load_p1  <= 1'b0;
    end else begin
      r_vld_p1   <= w_accept;
      r_fault_p1 <= w_accept && w_fault;
      r_load_p1  <= w_accept && !bus.req_we && !w_fault;
      case (r_state)
        ST_CLEAR: begin
          if (bus.clear_req) begin
            r_clr_cnt <= '0;
          end else if (r_clr_cnt == LAST_IDX) begin
            r_clr_cnt <= '0;
            r_state   <= ST_READY;
          end else begin
            r_clr_cnt <= r_clr_cnt + 1'b1;
          end
        end
        default: begin
          if (bus.clear_req) begin
            r_clr_cnt <= '0;
            r_state   <= ST_CLEAR;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_store) begin
      for (int b = 0; b < BYTES; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Stage p1: raw word and load attributes, extended on the way out.
  always_ff @(posedge clk) begin
    r_word_p1 <= r_mem[w_idx];
    r_size_p1 <= bus.req_size;
    r_lane_p1 <= w_lane;
    r_uns_p1  <= bus.req_unsigned;
  end

  assign bus.req_ready = (r_state == ST_READY);
  assign bus.busy      = (r_state == ST_CLEAR);
  assign bus.rsp_valid = r_vld_p1;
  assign bus.rsp_fault = r_fault_p1;
  assign bus.rsp_rdata = r_load_p1 ? w_ld_data : '0;

endmodule
